// File: rtl/calc_ctrl.sv
// Key-entry sequencer for the calculator datapath.
// Converts one-cycle key strobes into registered enable/clear pulses for the
// operand, operator and result registers, and runs the ALU start/done handshake.
module calc_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       alu_done,
  input  logic       alu_error,
  output logic [3:0] key_digit,
  output logic       a_shift,
  output logic       b_shift,
  output logic       a_clr,
  output logic       b_clr,
  output logic       a_from_res,
  output logic [1:0] op_code,
  output logic       op_en,
  output logic       alu_start,
  output logic       res_en,
  output logic [1:0] disp_sel,
  output logic       busy,
  output logic       key_drop
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] digit_cnt_reg, digit_cnt_next;
  logic             pend_clr_reg, pend_clr_next;
  logic [3:0]       key_digit_reg, key_digit_next;
  logic [1:0]       op_code_reg, op_code_next;
  logic [1:0]       disp_sel_reg, disp_sel_next;
  logic             a_shift_next, b_shift_next, a_clr_next, b_clr_next;
  logic             a_from_res_next, op_en_next, alu_start_next, res_en_next;
  logic             busy_next, key_drop_next;
  logic             a_shift_reg, b_shift_reg, a_clr_reg, b_clr_reg;
  logic             a_from_res_reg, op_en_reg, alu_start_reg, res_en_reg;
  logic             busy_reg, key_drop_reg;

  // Key classification; operator codes A..D map to 0..3.
  logic       is_digit, is_op, is_eq, is_clr, digit_ok, pend_eff;
  logic [1:0] key_op;
  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= 4'hA) && (key_code <= 4'hD);
  assign is_eq    = (key_code == 4'hE);
  assign is_clr   = (key_code == 4'hF);
  assign key_op   = key_code[1:0] - 2'd2;
  assign digit_ok = (digit_cnt_reg < CNT_MAX);
  // A clear arriving in the same cycle as alu_done still counts as pending.
  assign pend_eff = pend_clr_reg | (key_valid & is_clr);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_next      = state_reg;
    digit_cnt_next  = digit_cnt_reg;
    pend_clr_next   = pend_clr_reg;
    key_digit_next  = key_digit_reg;
    op_code_next    = op_code_reg;
    disp_sel_next   = disp_sel_reg;
    a_shift_next    = 1'b0;
    b_shift_next    = 1'b0;
    a_clr_next      = 1'b0;
    b_clr_next      = 1'b0;
    a_from_res_next = 1'b0;
    op_en_next      = 1'b0;
    alu_start_next  = 1'b0;
    res_en_next     = 1'b0;
    key_drop_next   = 1'b0;

    if (key_valid && is_clr && state_reg != S_EXEC) begin
      a_clr_next     = 1'b1;
      b_clr_next     = 1'b1;
      digit_cnt_next = '0;
      pend_clr_next  = 1'b0;
      disp_sel_next  = 2'd0;
      state_next     = S_A;
    end else begin
      case (state_reg)
        S_A: if (key_valid) begin
          if (is_digit && digit_ok) begin
            a_shift_next   = 1'b1;
            key_digit_next = key_code;
            digit_cnt_next = digit_cnt_reg + CNT_ONE;
          end else if (is_op) begin
            op_en_next     = 1'b1;
            op_code_next   = key_op;
            b_clr_next     = 1'b1;
            digit_cnt_next = '0;
            state_next     = S_OP;
          end else begin
            key_drop_next  = 1'b1;
          end
        end
        S_OP: if (key_valid) begin
          if (is_digit) begin
            b_shift_next   = 1'b1;
            key_digit_next = key_code;
            digit_cnt_next = CNT_ONE;
            disp_sel_next  = 2'd1;
            state_next     = S_B;
          end else if (is_op) begin
            op_en_next     = 1'b1;
            op_code_next   = key_op;
          end else begin
            key_drop_next  = 1'b1;
          end
        end
        S_B: if (key_valid) begin
          if (is_digit && digit_ok) begin
            b_shift_next   = 1'b1;
            key_digit_next = key_code;
            digit_cnt_next = digit_cnt_reg + CNT_ONE;
          end else if (is_eq) begin
            alu_start_next = 1'b1;
            state_next     = S_EXEC;
          end else begin
            key_drop_next  = 1'b1;
          end
        end
        S_EXEC: begin
          key_drop_next = key_valid & ~is_clr;
          pend_clr_next = pend_eff;
          if (alu_done) begin
            pend_clr_next = 1'b0;
            if (pend_eff) begin
              a_clr_next     = 1'b1;
              b_clr_next     = 1'b1;
              digit_cnt_next = '0;
              disp_sel_next  = 2'd0;
              state_next     = S_A;
            end else if (alu_error) begin
              disp_sel_next  = 2'd3;
              state_next     = S_ERR;
            end else begin
              res_en_next    = 1'b1;
              disp_sel_next  = 2'd2;
              state_next     = S_RES;
            end
          end
        end
        S_RES: if (key_valid) begin
          if (is_digit) begin
            a_clr_next      = 1'b1;
            a_shift_next    = 1'b1;
            key_digit_next  = key_code;
            digit_cnt_next  = CNT_ONE;
            disp_sel_next   = 2'd0;
            state_next      = S_A;
          end else if (is_op) begin
            a_from_res_next = 1'b1;
            op_en_next      = 1'b1;
            op_code_next    = key_op;
            b_clr_next      = 1'b1;
            digit_cnt_next  = '0;
            state_next      = S_OP;
          end else begin
            key_drop_next   = 1'b1;
          end
        end
        S_ERR: key_drop_next = key_valid;
        default: state_next = S_A;
      endcase
    end
    busy_next = (state_next == S_EXEC);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= S_A;
      digit_cnt_reg  <= '0;
      pend_clr_reg   <= 1'b0;
      key_digit_reg  <= 4'd0;
      op_code_reg    <= 2'd0;
      disp_sel_reg   <= 2'd0;
      a_shift_reg    <= 1'b0;
      b_shift_reg    <= 1'b0;
      a_clr_reg      <= 1'b0;
      b_clr_reg      <= 1'b0;
      a_from_res_reg <= 1'b0;
      op_en_reg      <= 1'b0;
      alu_start_reg  <= 1'b0;
      res_en_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      key_drop_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      digit_cnt_reg  <= digit_cnt_next;
      pend_clr_reg   <= pend_clr_next;
      key_digit_reg  <= key_digit_next;
      op_code_reg    <= op_code_next;
      disp_sel_reg   <= disp_sel_next;
      a_shift_reg    <= a_shift_next;
      b_shift_reg    <= b_shift_next;
      a_clr_reg      <= a_clr_next;
      b_clr_reg      <= b_clr_next;
      a_from_res_reg <= a_from_res_next;
      op_en_reg      <= op_en_next;
      alu_start_reg  <= alu_start_next;
      res_en_reg     <= res_en_next;
      busy_reg       <= busy_next;
      key_drop_reg   <= key_drop_next;
    end
  end

  assign key_digit  = key_digit_reg;
  assign a_shift    = a_shift_reg;
  assign b_shift    = b_shift_reg;
  assign a_clr      = a_clr_reg;
  assign b_clr      = b_clr_reg;
  assign a_from_res = a_from_res_reg;
  assign op_code    = op_code_reg;
  assign op_en      = op_en_reg;
  assign alu_start  = alu_start_reg;
  assign res_en     = res_en_reg;
  assign disp_sel   = disp_sel_reg;
  assign busy       = busy_reg;
  assign key_drop   = key_drop_reg;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed table-driven bench for calc_ctrl with hand-computed expectations.
module tb_calc_ctrl;

  logic       clock = 1'b0;
  logic       reset_n, key_valid, alu_done, alu_error;
  logic [3:0] key_code, key_digit;
  logic       a_shift, b_shift, a_clr, b_clr, a_from_res, op_en;
  logic       alu_start, res_en, busy, key_drop;
  logic [1:0] op_code, disp_sel;

  always #5 clock = ~clock;

  calc_ctrl #(.DIGITS(4)) dut (
    .clock(clock), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
    .alu_done(alu_done), .alu_error(alu_error), .key_digit(key_digit),
    .a_shift(a_shift), .b_shift(b_shift), .a_clr(a_clr), .b_clr(b_clr),
    .a_from_res(a_from_res), .op_code(op_code), .op_en(op_en),
    .alu_start(alu_start), .res_en(res_en), .disp_sel(disp_sel),
    .busy(busy), .key_drop(key_drop)
  );

  // Pulse flag bits: {a_shift,b_shift,a_clr,b_clr,a_from_res,op_en,alu_start,res_en,key_drop}
  localparam logic [8:0] NONE = 9'd0;
  localparam logic [8:0] ASH  = 9'b1_0000_0000;
  localparam logic [8:0] BSH  = 9'b0_1000_0000;
  localparam logic [8:0] ACL  = 9'b0_0100_0000;
  localparam logic [8:0] BCL  = 9'b0_0010_0000;
  localparam logic [8:0] AFR  = 9'b0_0001_0000;
  localparam logic [8:0] OPE  = 9'b0_0000_1000;
  localparam logic [8:0] STA  = 9'b0_0000_0100;
  localparam logic [8:0] REN  = 9'b0_0000_0010;
  localparam logic [8:0] DRP  = 9'b0_0000_0001;

  typedef struct {
    string      name;
    logic       kv;
    logic [3:0] kc;
    logic       done;
    logic       err;
    logic [8:0] fl;
    logic [3:0] dig;
    logic [1:0] opc;
    logic [1:0] ds;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input string nm, input logic kv, input logic [3:0] kc,
                     input logic dn, input logic er, input logic [8:0] fl,
                     input logic [3:0] dg, input logic [1:0] oc,
                     input logic [1:0] ds, input logic bs);
    vec_t v;
    v.name = nm; v.kv = kv; v.kc = kc; v.done = dn; v.err = er;
    v.fl = fl; v.dig = dg; v.opc = oc; v.ds = ds; v.bsy = bs;
    vecs.push_back(v);
  endtask

  function automatic logic [8:0] flags_now();
    return {a_shift, b_shift, a_clr, b_clr, a_from_res, op_en, alu_start, res_en, key_drop};
  endfunction

  task automatic check(input vec_t v);
    logic [8:0] fl;
    logic       ok;
    fl = flags_now();
    ok = (fl == v.fl) && (disp_sel == v.ds) && (busy == v.bsy);
    if ((v.fl & (ASH | BSH)) != 9'd0 && key_digit != v.dig) ok = 1'b0;
    if ((v.fl & OPE) != 9'd0 && op_code != v.opc) ok = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got flags=%b ds=%0d busy=%b dig=%0d op=%0d, want flags=%b ds=%0d busy=%b dig=%0d op=%0d",
               v.name, fl, disp_sel, busy, key_digit, op_code, v.fl, v.ds, v.bsy, v.dig, v.opc);
    end else begin
      $display("[TB] %-24s flags=%b ds=%0d busy=%b dig=%0d op=%0d ok",
               v.name, fl, disp_sel, busy, key_digit, op_code);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    key_valid = v.kv; key_code = v.kc; alu_done = v.done; alu_error = v.err;
    @(posedge clock);
    #1;
    key_valid = 1'b0; alu_done = 1'b0; alu_error = 1'b0;
    check(v);
  endtask

  task automatic check_zero(input string nm);
    logic [18:0] all;
    all = {flags_now(), disp_sel, busy, key_digit, op_code};
    tests++;
    if (all != 19'd0) begin
      fails++;
      $display("FAIL %s: outputs=%h, want all zero", nm, all);
    end else begin
      $display("[TB] %-24s all outputs zero ok", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rv;
    reset_n = 1'b0; key_valid = 1'b0; key_code = 4'd0; alu_done = 1'b0; alu_error = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset_initial");
    @(negedge clock);
    reset_n = 1'b1;

    // Basic add: 1,2,A,3,E, done
    add("a_digit1",     1, 4'h1, 0, 0, ASH,       1, 0, 0, 0);
    add("a_digit2",     1, 4'h2, 0, 0, ASH,       2, 0, 0, 0);
    add("op_add",       1, 4'hA, 0, 0, OPE | BCL, 0, 0, 0, 0);
    add("b_digit3",     1, 4'h3, 0, 0, BSH,       3, 0, 1, 0);
    add("equals_start", 1, 4'hE, 0, 0, STA,       0, 0, 1, 1);
    add("exec_idle",    0, 4'h0, 0, 0, NONE,      0, 0, 1, 1);
    add("done_ok",      0, 4'h0, 1, 0, REN,       0, 0, 2, 0);
    add("res_idle",     0, 4'h0, 0, 0, NONE,      0, 0, 2, 0);
    // Chain from result with sub, operator replacement, op in S_B dropped
    add("res_chain_sub",1, 4'hB, 0, 0, AFR | OPE | BCL, 0, 1, 2, 0);
    add("op_eq_drop",   1, 4'hE, 0, 0, DRP,       0, 0, 2, 0);
    add("op_replace",   1, 4'hC, 0, 0, OPE,       0, 2, 2, 0);
    add("b_digit4",     1, 4'h4, 0, 0, BSH,       4, 0, 1, 0);
    add("b_op_drop",    1, 4'hA, 0, 0, DRP,       0, 0, 1, 0);
    add("equals2",      1, 4'hE, 0, 0, STA,       0, 0, 1, 1);
    add("done_ok2",     0, 4'h0, 1, 0, REN,       0, 0, 2, 0);
    add("res_digit9",   1, 4'h9, 0, 0, ACL | ASH, 9, 0, 0, 0);
    add("clear_a",      1, 4'hF, 0, 0, ACL | BCL, 0, 0, 0, 0);
    // Digit limit
    add("lim_d1",       1, 4'h1, 0, 0, ASH,       1, 0, 0, 0);
    add("lim_d2",       1, 4'h2, 0, 0, ASH,       2, 0, 0, 0);
    add("lim_d3",       1, 4'h3, 0, 0, ASH,       3, 0, 0, 0);
    add("lim_d4",       1, 4'h4, 0, 0, ASH,       4, 0, 0, 0);
    add("lim_d5_drop",  1, 4'h5, 0, 0, DRP,       0, 0, 0, 0);
    add("lim_d6_drop",  1, 4'h6, 0, 0, DRP,       0, 0, 0, 0);
    add("a_eq_drop",    1, 4'hE, 0, 0, DRP,       0, 0, 0, 0);
    add("clear_lim",    1, 4'hF, 0, 0, ACL | BCL, 0, 0, 0, 0);
    // Clear pending during execution
    add("pc_a2",        1, 4'h2, 0, 0, ASH,       2, 0, 0, 0);
    add("pc_add",       1, 4'hA, 0, 0, OPE | BCL, 0, 0, 0, 0);
    add("pc_b5",        1, 4'h5, 0, 0, BSH,       5, 0, 1, 0);
    add("pc_eq",        1, 4'hE, 0, 0, STA,       0, 0, 1, 1);
    add("pc_key7_drop", 1, 4'h7, 0, 0, DRP,       0, 0, 1, 1);
    add("pc_clear",     1, 4'hF, 0, 0, NONE,      0, 0, 1, 1);
    add("pc_done",      0, 4'h0, 1, 0, ACL | BCL, 0, 0, 0, 0);
    add("pc_in_a",      1, 4'h1, 0, 0, ASH,       1, 0, 0, 0);
    // Error path
    add("er_clear",     1, 4'hF, 0, 0, ACL | BCL, 0, 0, 0, 0);
    add("er_a8",        1, 4'h8, 0, 0, ASH,       8, 0, 0, 0);
    add("er_div",       1, 4'hD, 0, 0, OPE | BCL, 0, 3, 0, 0);
    add("er_b0",        1, 4'h0, 0, 0, BSH,       0, 0, 1, 0);
    add("er_eq",        1, 4'hE, 0, 0, STA,       0, 0, 1, 1);
    add("er_done",      0, 4'h0, 1, 1, NONE,      0, 0, 3, 0);
    add("er_key5_drop", 1, 4'h5, 0, 0, DRP,       0, 0, 3, 0);
    add("er_eq_drop",   1, 4'hE, 0, 0, DRP,       0, 0, 3, 0);
    add("er_op_drop",   1, 4'hA, 0, 0, DRP,       0, 0, 3, 0);
    add("er_clear_out", 1, 4'hF, 0, 0, ACL | BCL, 0, 0, 0, 0);
    // Key coinciding with alu_done
    add("co_a1",        1, 4'h1, 0, 0, ASH,       1, 0, 0, 0);
    add("co_sub",       1, 4'hB, 0, 0, OPE | BCL, 0, 1, 0, 0);
    add("co_b2",        1, 4'h2, 0, 0, BSH,       2, 0, 1, 0);
    add("co_eq",        1, 4'hE, 0, 0, STA,       0, 0, 1, 1);
    add("co_key_done",  1, 4'h3, 1, 0, DRP | REN, 0, 0, 2, 0);
    add("co_res_add",   1, 4'hA, 0, 0, AFR | OPE | BCL, 0, 0, 2, 0);
    add("co_b6",        1, 4'h6, 0, 0, BSH,       6, 0, 1, 0);
    add("co_eq2",       1, 4'hE, 0, 0, STA,       0, 0, 1, 1);
    add("co_clr_done",  1, 4'hF, 1, 0, ACL | BCL, 0, 0, 0, 0);
    add("co_in_a",      1, 4'h4, 0, 0, ASH,       4, 0, 0, 0);
    add("stray_done",   0, 4'h0, 1, 1, NONE,      0, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset held two cycles in the middle of an execution
    vecs.delete();
    add("rs_clear",     1, 4'hF, 0, 0, ACL | BCL, 0, 0, 0, 0);
    add("rs_a7",        1, 4'h7, 0, 0, ASH,       7, 0, 0, 0);
    add("rs_mul",       1, 4'hC, 0, 0, OPE | BCL, 0, 2, 0, 0);
    add("rs_b2",        1, 4'h2, 0, 0, BSH,       2, 0, 1, 0);
    add("rs_eq",        1, 4'hE, 0, 0, STA,       0, 0, 1, 1);
    foreach (vecs[i]) apply(vecs[i]);

    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_zero("reset_exec_cycle1");
    @(negedge clock);
    key_valid = 1'b1; key_code = 4'h3;
    @(posedge clock); #1;
    key_valid = 1'b0;
    check_zero("reset_exec_cycle2");
    @(negedge clock);
    reset_n = 1'b1;

    add("late_done_ign", 0, 4'h0, 1, 0, NONE,     0, 0, 0, 0);
    rv = vecs[$];
    apply(rv);
    add("post_reset_a5", 1, 4'h5, 0, 0, ASH,      5, 0, 0, 0);
    rv = vecs[$];
    apply(rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
